wb_burst_master: RTL and testbench

//  Pipelined Wishbone B4 initiator. Turns one burst command (read or write, 1..MAX_BEATS

---
 rtl/wb_burst_master.sv | 156 +++++++++++++++
 tb/tb_wb_burst_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Pipelined Wishbone B4 burst initiator: one read/write command becomes a stream of
// back-to-back stb requests with stall handling and a bound on unacknowledged requests.
module wb_burst_master #(
  parameter  int DATA_WIDTH      = 128,
  parameter  int AW              = 22,
  parameter  int MAX_BEATS       = 16,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int LW              = $clog2(MAX_BEATS),
  localparam int SW              = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [AW-1:0]         cmd_addr_i,
  input  logic [LW-1:0]         cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [SW-1:0]         wsel_i,
  output logic                  rdata_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [AW-1:0]         wb_addr_o,
  output logic [SW-1:0]         wb_sel_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o,
  input  logic [DATA_WIDTH-1:0] wb_rdata_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  localparam int CW = LW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state_q;
  logic                  we_q, held_q, cyc_q, err_q;
  logic [AW-1:0]         addr_q;
  logic [LW-1:0]         len_q;
  logic [CW-1:0]         issued_q, consumed_q, last_cnt;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         sel_q;

  logic stb, accept, cyc, resp_live, resp, resp_bad;
  logic beats_left, writes_left, wfire, last_accept;

  assign last_cnt    = {1'b0, len_q};
  assign beats_left  = issued_q <= last_cnt;
  assign writes_left = consumed_q <= last_cnt;

  assign stb = (state_q == ISSUE) && beats_left && (outstanding_q < OW'(MAX_OUTSTANDING))
               && (!we_q || held_q);
  assign accept      = stb && !wb_stall_i;
  assign last_accept = accept && (issued_q == last_cnt);
  assign cyc         = stb || cyc_q;

  // Responses arriving outside a live cycle or with nothing in flight are stray.
  assign resp_live = cyc && (outstanding_q != '0);
  assign resp      = resp_live && (wb_ack_i || wb_err_i || wb_rty_i);
  assign resp_bad  = resp_live && (wb_err_i || wb_rty_i);

  // After an error the producer is still drained so its beat count stays aligned.
  assign wdata_ready_o = we_q && writes_left &&
                         (((state_q == ISSUE) && (!held_q || accept)) ||
                          ((state_q == DRAIN) && err_q));
  assign wfire = wdata_valid_i && wdata_ready_o;

  assign cmd_ready_o   = (state_q == IDLE);
  assign done_o        = (state_q == DONE);
  assign err_o         = (state_q == DONE) && err_q;
  assign rdata_valid_o = wb_ack_i && resp_live && !we_q && !err_q;
  assign rdata_o       = wb_rdata_i;
  assign wb_cyc_o      = cyc;
  assign wb_stb_o      = stb;
  assign wb_we_o       = we_q;
  assign wb_addr_o     = addr_q;
  assign wb_sel_o      = sel_q;
  assign wb_wdata_o    = wdata_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !resp)      outstanding_d = outstanding_q + OW'(1);
    else if (!accept && resp) outstanding_d = outstanding_q - OW'(1);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      held_q        <= 1'b0;
      cyc_q         <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      consumed_q    <= '0;
      outstanding_q <= '0;
      wdata_q       <= '0;
      sel_q         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (stb)      cyc_q <= 1'b1;
      if (resp_bad) err_q <= 1'b1;
      if (accept) begin
        addr_q   <= addr_q + AW'(1);
        issued_q <= issued_q + CW'(1);
      end
      if (wfire) consumed_q <= consumed_q + CW'(1);
      if (wfire && (state_q == ISSUE)) begin
        wdata_q <= wdata_i;
        sel_q   <= wsel_i;
        held_q  <= 1'b1;
      end else if (accept) begin
        held_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            state_q    <= ISSUE;
            we_q       <= cmd_we_i;
            addr_q     <= cmd_addr_i;
            len_q      <= cmd_len_i;
            issued_q   <= '0;
            consumed_q <= '0;
            held_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= cmd_we_i ? '0 : '1;
          end
        end
        ISSUE: begin
          if (last_accept || resp_bad) state_q <= DRAIN;
        end
        DRAIN: begin
          if ((outstanding_q == '0) && (!we_q || !writes_left)) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: in-bench Wishbone responder and write-beat producer,
// one task per scenario with inline comparisons against hand-computed values.
module tb_wb_burst_master;

  localparam int DW   = 128;
  localparam int AW   = 22;
  localparam int SW   = DW / 8;
  localparam int LW   = 4;
  localparam int MAXO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          wdata_valid_i, wdata_ready_o;
  logic [DW-1:0] wdata_i;
  logic [SW-1:0] wsel_i;
  logic          rdata_valid_o, done_o, err_o;
  logic [DW-1:0] rdata_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_wdata_o, wb_rdata_i;
  logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  always #5 clk = ~clk;

  wb_burst_master dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i), .wsel_i(wsel_i),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_sel_o(wb_sel_o), .wb_wdata_o(wb_wdata_o), .wb_rdata_i(wb_rdata_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Responder and observation state.
  int            cyc_n = 0, bc = 0;
  int            rsp_delay, err_idx, stale = 0, tb_out = 0;
  int            due_q[$];
  logic          bad_q[$];
  logic [AW-1:0] raddr_q[$];
  int            acc_n, first_acc, last_acc, max_out, full_stb;
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] acc_wdata[$];
  logic [SW-1:0] acc_sel[$];
  logic [DW-1:0] rd_q[$];
  int            done_n, done_cyc_hi, stall_holds, unstable, err_seen_cyc, stb_after_err;
  int            cyc_hi_n;
  logic          done_err, cmd_rdy_seen;
  int            wr_total, wr_idx;
  logic          stall_en, force_stall;
  int            stall_lo, stall_hi;
  logic          prev_hold, prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic [SW-1:0] prev_sel;

  function automatic logic [DW-1:0] mk_rdata(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return {w ^ 32'hA5A5_0000, ~w, w + 32'h0100_0000, w};
  endfunction

  function automatic logic [DW-1:0] mk_wdata(input int i);
    logic [31:0] w;
    w = 32'(i);
    return {w | 32'h5A00_0000, ~w, w ^ 32'h00FF_00FF, w + 32'h0000_1234};
  endfunction

  function automatic logic [SW-1:0] mk_sel(input int i);
    logic [31:0] s;
    s = 32'h0000_FFFF >> i;
    return s[SW-1:0] ^ 16'h0100;
  endfunction

  task automatic clear_stats();
    acc_n = 0; first_acc = 0; last_acc = 0; max_out = 0; full_stb = 0;
    acc_addr.delete(); acc_wdata.delete(); acc_sel.delete(); rd_q.delete();
    done_n = 0; done_err = 1'b0; done_cyc_hi = 0; stall_holds = 0; unstable = 0;
    err_seen_cyc = -1; stb_after_err = 0; cyc_hi_n = 0; cmd_rdy_seen = 1'b0;
    wr_total = 0; wr_idx = 0; stall_en = 1'b0; stall_lo = 0; stall_hi = 0;
    err_idx = -1; rsp_delay = 1; bc = 0; prev_hold = 1'b0;
  endtask

  // One bus cycle: drive responder/producer inputs, observe settled outputs, take the edge.
  task automatic step();
    int  out_now;
    logic acc;
    out_now = tb_out;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rdata_i = '0;
    if (due_q.size() > 0 && due_q[0] <= cyc_n) begin
      if (bad_q[0]) begin
        wb_err_i = 1'b1;
        err_seen_cyc = cyc_n;
      end else begin
        wb_ack_i = 1'b1;
      end
      wb_rdata_i = mk_rdata(raddr_q[0]);
      void'(due_q.pop_front());
      void'(bad_q.pop_front());
      void'(raddr_q.pop_front());
      if (stale > 0) stale--;
      else tb_out--;
    end
    wb_stall_i    = force_stall || (stall_en && bc >= stall_lo && bc < stall_hi);
    wdata_valid_i = wr_idx < wr_total;
    wdata_i       = mk_wdata(wr_idx);
    wsel_i        = mk_sel(wr_idx);
    #1;
    acc = wb_cyc_o && wb_stb_o && !wb_stall_i;
    cmd_rdy_seen = cmd_ready_o;
    if (wb_cyc_o || wb_stb_o) cyc_hi_n++;
    if (prev_hold && (!wb_stb_o || wb_addr_o !== prev_addr || wb_wdata_o !== prev_wdata ||
                      wb_sel_o !== prev_sel || wb_we_o !== prev_we)) unstable++;
    prev_hold  = wb_stb_o && wb_stall_i;
    prev_addr  = wb_addr_o;
    prev_wdata = wb_wdata_o;
    prev_sel   = wb_sel_o;
    prev_we    = wb_we_o;
    if (wb_stb_o && wb_stall_i) stall_holds++;
    if (wb_stb_o && out_now >= MAXO) full_stb++;
    if (wb_stb_o && err_seen_cyc >= 0 && cyc_n > err_seen_cyc) stb_after_err++;
    if (acc) begin
      acc_addr.push_back(wb_addr_o);
      acc_wdata.push_back(wb_wdata_o);
      acc_sel.push_back(wb_sel_o);
      due_q.push_back(cyc_n + rsp_delay);
      bad_q.push_back(acc_n == err_idx);
      raddr_q.push_back(wb_addr_o);
      if (acc_n == 0) first_acc = cyc_n;
      last_acc = cyc_n;
      acc_n++;
      tb_out++;
    end
    if (tb_out > max_out) max_out = tb_out;
    if (wdata_valid_i && wdata_ready_o) wr_idx++;
    if (rdata_valid_o) rd_q.push_back(rdata_o);
    if (done_o) begin
      done_n++;
      done_err = err_o;
      if (wb_cyc_o) done_cyc_hi++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    bc++;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (done_n == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done_o count 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    n_checks++;
    if ({cmd_ready_o, wb_cyc_o, wb_stb_o, done_o, err_o, wdata_ready_o, rdata_valid_o, wb_we_o}
        !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 10000000",
               {cmd_ready_o, wb_cyc_o, wb_stb_o, done_o, err_o, wdata_ready_o, rdata_valid_o, wb_we_o});
    end
    n_checks++;
    if (wb_addr_o !== '0 || wb_sel_o !== '0 || wb_wdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: addr %h sel %h required 0", wb_addr_o, wb_sel_o);
    end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_read_basic();
    clear_stats();
    issue(1'b0, 22'h10, 4'd3);
    n_checks++;
    if (cmd_rdy_seen !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_ready: got %b required 1", cmd_rdy_seen); end
    wait_done("rd", 50);
    n_checks++;
    if (acc_n !== 4) begin n_fail++; $display("FAIL rd_accepts: got %0d required 4", acc_n); end
    n_checks++;
    if (last_acc - first_acc !== 3) begin n_fail++; $display("FAIL rd_back_to_back: span %0d required 3", last_acc - first_acc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= acc_n || acc_addr[i] !== AW'(32'h10 + i)) begin
        n_fail++; $display("FAIL rd_addr[%0d]: got %h required %h", i, (i < acc_n) ? acc_addr[i] : 'x, 32'h10 + i);
      end
      n_checks++;
      if (i >= rd_q.size() || rd_q[i] !== mk_rdata(AW'(32'h10 + i))) begin
        n_fail++; $display("FAIL rd_data[%0d]: got %h required %h", i, (i < rd_q.size()) ? rd_q[i] : 'x, mk_rdata(AW'(32'h10 + i)));
      end
    end
    n_checks++;
    if (rd_q.size() !== 4) begin n_fail++; $display("FAIL rd_count: got %0d required 4", rd_q.size()); end
    n_checks++;
    if (done_n !== 1 || done_err !== 1'b0) begin n_fail++; $display("FAIL rd_done: done %0d err %b required 1/0", done_n, done_err); end
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rd_idle_after: cmd_ready %b required 1", cmd_ready_o); end
  endtask

  task automatic test_write_stall();
    clear_stats();
    wr_total = 8; stall_en = 1'b1; stall_lo = 4; stall_hi = 7;
    issue(1'b1, 22'h200, 4'd7);
    wait_done("wr_stall", 80);
    n_checks++;
    if (acc_n !== 8) begin n_fail++; $display("FAIL wr_accepts: got %0d required 8", acc_n); end
    n_checks++;
    if (stall_holds !== 3) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d required 3", stall_holds); end
    n_checks++;
    if (unstable !== 0) begin n_fail++; $display("FAIL wr_stall_stable: %0d changes while stalled, required 0", unstable); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= acc_n || acc_addr[i] !== AW'(32'h200 + i) || acc_wdata[i] !== mk_wdata(i) ||
          acc_sel[i] !== mk_sel(i)) begin
        n_fail++;
        $display("FAIL wr_beat[%0d]: addr %h sel %h required addr %h sel %h", i,
                 (i < acc_n) ? acc_addr[i] : 'x, (i < acc_n) ? acc_sel[i] : 'x, 32'h200 + i, mk_sel(i));
      end
    end
    n_checks++;
    if (wr_idx !== 8) begin n_fail++; $display("FAIL wr_consumed: got %0d required 8", wr_idx); end
    n_checks++;
    if (done_n !== 1 || done_err !== 1'b0 || done_cyc_hi !== 0) begin
      n_fail++; $display("FAIL wr_done: done %0d err %b cyc_in_done %0d required 1/0/0", done_n, done_err, done_cyc_hi);
    end
    n_checks++;
    if (rd_q.size() !== 0) begin n_fail++; $display("FAIL wr_no_rdata: got %0d required 0", rd_q.size()); end
  endtask

  task automatic test_outstanding();
    clear_stats();
    rsp_delay = 20;
    issue(1'b0, 22'h100, 4'd15);
    wait_done("outst", 200);
    n_checks++;
    if (max_out !== 8) begin n_fail++; $display("FAIL outst_max: got %0d required 8", max_out); end
    n_checks++;
    if (full_stb !== 0) begin n_fail++; $display("FAIL outst_stb_at_limit: got %0d cycles required 0", full_stb); end
    n_checks++;
    if (acc_n !== 16 || rd_q.size() !== 16) begin
      n_fail++; $display("FAIL outst_beats: accepts %0d rdata %0d required 16/16", acc_n, rd_q.size());
    end
    for (int i = 0; i < 16; i += 5) begin
      n_checks++;
      if (i >= rd_q.size() || rd_q[i] !== mk_rdata(AW'(32'h100 + i))) begin
        n_fail++; $display("FAIL outst_data[%0d]: got %h required %h", i, (i < rd_q.size()) ? rd_q[i] : 'x, mk_rdata(AW'(32'h100 + i)));
      end
    end
    n_checks++;
    if (done_n !== 1 || done_err !== 1'b0) begin n_fail++; $display("FAIL outst_done: done %0d err %b required 1/0", done_n, done_err); end
  endtask

  task automatic test_error();
    clear_stats();
    wr_total = 4; err_idx = 1;
    issue(1'b1, 22'h300, 4'd3);
    wait_done("err", 60);
    n_checks++;
    if (stb_after_err !== 0) begin n_fail++; $display("FAIL err_stb_after: got %0d cycles required 0", stb_after_err); end
    n_checks++;
    if (acc_n >= 4 || acc_n < 2) begin n_fail++; $display("FAIL err_accepts: got %0d required 2..3", acc_n); end
    n_checks++;
    if (wr_idx !== 4) begin n_fail++; $display("FAIL err_consumed: got %0d required 4", wr_idx); end
    n_checks++;
    if (done_n !== 1 || done_err !== 1'b1) begin n_fail++; $display("FAIL err_done: done %0d err %b required 1/1", done_n, done_err); end
  endtask

  task automatic test_wrap();
    clear_stats();
    issue(1'b0, 22'h3FFFFF, 4'd1);
    wait_done("wrap", 40);
    n_checks++;
    if (acc_n !== 2 || acc_addr[0] !== 22'h3FFFFF || acc_addr[1] !== 22'h000000) begin
      n_fail++; $display("FAIL wrap_addr: accepts %0d got %h,%h required 3fffff,000000", acc_n,
                         (acc_n > 0) ? acc_addr[0] : 'x, (acc_n > 1) ? acc_addr[1] : 'x);
    end
    n_checks++;
    if (rd_q.size() !== 2 || rd_q[1] !== mk_rdata(22'h0)) begin
      n_fail++; $display("FAIL wrap_data: count %0d required 2 with beat1 %h", rd_q.size(), mk_rdata(22'h0));
    end
    n_checks++;
    if (done_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b required 0", done_err); end
  endtask

  task automatic test_reset_midburst();
    int n;
    clear_stats();
    rsp_delay = 10;
    issue(1'b0, 22'h40, 4'd7);
    n = 0;
    while (tb_out < 3 && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (tb_out !== 3) begin n_fail++; $display("FAIL rstmid_inflight: got %0d required 3", tb_out); end
    force_stall = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    force_stall = 1'b0;
    stale = tb_out;
    tb_out = 0;
    clear_stats();
    for (int i = 0; i < 15; i++) step();
    n_checks++;
    if (cyc_hi_n !== 0) begin n_fail++; $display("FAIL rstmid_cyc: got %0d active cycles required 0", cyc_hi_n); end
    n_checks++;
    if (done_n !== 0 || rd_q.size() !== 0) begin
      n_fail++; $display("FAIL rstmid_late_resp: done %0d rdata %0d required 0/0", done_n, rd_q.size());
    end
    clear_stats();
    issue(1'b0, 22'h20, 4'd1);
    n_checks++;
    if (cmd_rdy_seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_ready: got %b required 1", cmd_rdy_seen); end
    wait_done("rstmid_new", 40);
    n_checks++;
    if (rd_q.size() !== 2 || rd_q[0] !== mk_rdata(22'h20) || rd_q[1] !== mk_rdata(22'h21) || done_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_new_burst: rdata count %0d err %b required 2/0", rd_q.size(), done_err);
    end
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; wsel_i = '0; wb_rdata_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; force_stall = 1'b0;
    clear_stats();
    @(posedge clk);
    #1;
    test_reset();
    test_read_basic();
    test_write_stall();
    test_outstanding();
    test_error();
    test_wrap();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
